fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipeline.
- Generates the PC and fetches from instruction memory over a ready handshake.
- Registers instruction, PC and PC+4 into the Decode stage; instr_d[6:0] drives the main decoder's op input.
- Accepts stall and flush from the hazard unit, and branch/jump redirects from Execute.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: widths, the canonical NOP, major opcodes
// and the fetch-stage state type.
package rv_pkg;

  localparam int DEFAULT_XLEN = 32;

  // addi x0, x0, 0 -- the bubble the pipeline registers fall back to
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with flush > stall > load priority; a cycle with
// neither flush, stall nor load also produces a bubble.
module if_id_reg #(
  parameter int           W      = 96,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] q_reg;
  logic         valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg     <= BUBBLE;
      valid_reg <= 1'b0;
    end else if (flush) begin
      q_reg     <= BUBBLE;
      valid_reg <= 1'b0;
    end else if (stall) begin
      q_reg     <= q_reg;
      valid_reg <= valid_reg;
    end else if (load) begin
      q_reg     <= data;
      valid_reg <= 1'b1;
    end else begin
      q_reg     <= BUBBLE;
      valid_reg <= 1'b0;
    end
  end

  assign q     = q_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC generation, ready-handshake fetch FSM and the
// IF/ID pipeline register feeding Decode.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_err
);

  localparam int PAYLOAD_W = 32 + 2 * XLEN;
  localparam logic [PAYLOAD_W-1:0] BUBBLE_WORD = {NOP_INSTR, {(2 * XLEN){1'b0}}};

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_f_reg, pc_f_next;
  logic            misalign_reg;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] target_aligned;
  logic            fetch_done;

  assign pc_plus4_f     = pc_f_reg + XLEN'(4);
  assign target_aligned = {pc_target_e[XLEN-1:2], 2'b00};
  assign fetch_done     = imem_req && imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_f_reg     <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_f_reg     <= pc_f_next;
      if (pc_src_e && (pc_target_e[1:0] != 2'b00))
        misalign_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (!pc_src_e && !imem_ready)
          state_next = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (pc_src_e || imem_ready)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // A redirect outranks every hold condition, including stall_f.
  always_comb begin
    pc_f_next = pc_f_reg;
    if (pc_src_e)
      pc_f_next = target_aligned;
    else if (!stall_f && fetch_done)
      pc_f_next = pc_plus4_f;
  end

  assign imem_addr    = pc_f_reg;
  assign misalign_err = misalign_reg;

  logic [PAYLOAD_W-1:0] if_id_data;
  logic [PAYLOAD_W-1:0] if_id_q;

  assign if_id_data = {imem_rdata, pc_f_reg, pc_plus4_f};

  // The word returned alongside a redirect is wrong-path, so pc_src_e flushes too.
  if_id_reg #(
    .W      (PAYLOAD_W),
    .BUBBLE (BUBBLE_WORD)
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_d || pc_src_e),
    .stall (stall_d),
    .load  (fetch_done && !stall_f),
    .data  (if_id_data),
    .q     (if_id_q),
    .valid (valid_d)
  );

  assign instr_d    = if_id_q[PAYLOAD_W-1 -: 32];
  assign pc_d       = if_id_q[2*XLEN-1 -: XLEN];
  assign pc_plus4_d = if_id_q[XLEN-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_err;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: fetching is active from the first cycle after reset,
  // the PC advances on every accepted fetch, and Decode sees what was accepted.
  bit          m_active;
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  bit          m_valid, m_mis;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0;
    m_valid = 0; m_mis = 0;
  endtask

  task automatic model_update();
    bit accepted;
    if (!rst_n) begin
      model_reset();
      return;
    end
    accepted = m_active && imem_ready;
    if (flush_d || pc_src_e) begin
      m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    end else if (stall_d) begin
      // Decode keeps what it has
    end else if (accepted && !stall_f) begin
      m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
    end else begin
      m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    end
    if (pc_src_e) begin
      m_pc = pc_target_e & ~32'd3;
      if (pc_target_e[1:0] != 2'b00) m_mis = 1;
    end else if (!stall_f && accepted) begin
      m_pc = m_pc + 32'd4;
    end
    m_active = 1;
  endtask

  task automatic compare_all();
    check("imem_req",     {31'b0, imem_req},     {31'b0, m_active});
    check("imem_addr",    imem_addr,             m_pc);
    check("instr_d",      instr_d,               m_instr);
    check("pc_d",         pc_d,                  m_pcd);
    check("pc_plus4_d",   pc_plus4_d,            m_pc4);
    check("valid_d",      {31'b0, valid_d},      {31'b0, m_valid});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  // Inputs are applied 1 time unit after an edge, then one clock is taken.
  task automatic step(input bit sf, input bit sd, input bit fd, input bit ps,
                      input logic [31:0] tgt, input bit rdy);
    stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = ps;
    pc_target_e = tgt; imem_ready = rdy;
    imem_rdata = mem_word(imem_addr);
    @(posedge clk); #1;
    model_update();
    compare_all();
  endtask

  initial begin
    rst_n = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
    pc_target_e = 0; imem_ready = 1; imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_instr", instr_d, 32'h0000_0013);
    rst_n = 1;

    // Bring-up: one idle cycle, then sequential fetch from address 0
    check("cyc1_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("cyc2_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    check("cyc3_instr", instr_d, 32'h0050_0093);
    check("cyc3_pc4", pc_plus4_d, 32'h4);
    check("cyc3_addr", imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    check("second_instr", instr_d, 32'h00A0_0113);

    // Memory not ready for three cycles at address 8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_valid", {31'b0, valid_d}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 1);
    check("after_wait_pc", pc_d, 32'h8);

    // Redirect while fetching 0x10
    step(0, 0, 0, 0, 0, 1);
    check("pre_redirect_addr", imem_addr, 32'h10);
    step(0, 0, 0, 1, 32'h40, 1);
    check("redirect_bubble", instr_d, 32'h0000_0013);
    check("redirect_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0, 0, 1);
    check("redirect_pc_d", pc_d, 32'h40);

    // Both stalls held for two cycles with 0x14 in Decode
    step(0, 0, 0, 1, 32'h14, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 0, 1);
      check("stall_pc_d", pc_d, 32'h14);
      check("stall_addr", imem_addr, 32'h18);
    end
    step(0, 0, 0, 0, 0, 1);
    check("unstall_pc_d", pc_d, 32'h18);

    // Misaligned redirect target, with stall_f also high
    step(1, 0, 0, 1, 32'h42, 1);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);
    check("misalign_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Flush beats stall
    step(0, 1, 1, 0, 0, 1);
    check("flush_stall_valid", {31'b0, valid_d}, 32'd0);
    check("flush_stall_instr", instr_d, 32'h0000_0013);

    // PC wraparound
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", pc_plus4_d, 32'h0);

    // Asynchronous reset while waiting on memory
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    rst_n = 1;
    check("rst_release_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("restart_addr", imem_addr, 32'h0);

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit sf, sd, fd, ps, rdy;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 9) == 0);
      sd  = ($urandom_range(0, 9) == 0);
      fd  = ($urandom_range(0, 14) == 0);
      ps  = ($urandom_range(0, 14) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      rst_n = ($urandom_range(0, 299) != 0);
      step(sf, sd, fd, ps, tgt, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
